// File: rtl/nios_mtl_led_pio_pkg.sv
// Shared constants for the LED PIO: register word addresses and the prescaler width.
package nios_mtl_led_pio_pkg;

    localparam int unsigned PERIOD_W = 32;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

endpackage

// File: rtl/nios_mtl_blink_timer.sv
// Blink prescaler: toggles phase every PERIOD+1 cycles; PERIOD==0 parks phase high.
module nios_mtl_blink_timer
    import nios_mtl_led_pio_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    input  logic [PERIOD_W-1:0] period_reset,
    output logic                phase
);

    logic [PERIOD_W-1:0] r_count;
    logic                r_phase;
    logic [PERIOD_W-1:0] w_compare;

    // While reset is held the period register is being reloaded, so compare against its reset value.
    always_comb begin
        w_compare = period;
        if (reset) begin
            w_compare = period_reset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || restart || (w_compare == '0)) begin
            r_count <= '0;
            r_phase <= 1'b1;
        end else if (r_count == w_compare) begin
            r_count <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign phase = r_phase;

endmodule

// File: rtl/nios_mtl_led_pio.sv
// Avalon-MM LED output port with atomic set/clear, per-bit blink and registered read-back.
module nios_mtl_led_pio
    import nios_mtl_led_pio_pkg::*;
#(
    parameter int unsigned         WIDTH        = 8,
    parameter logic [31:0]         RESET_VALUE  = 32'd0,
    parameter logic [PERIOD_W-1:0] PERIOD_RESET = 32'd12_499_999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]    r_data_out;
    logic [WIDTH-1:0]    r_blink_en;
    logic [PERIOD_W-1:0] r_period;
    logic [31:0]         r_readdata;

    logic                w_wr;
    logic                w_rd;
    logic                w_restart;
    logic                w_phase;
    logic [WIDTH-1:0]    w_wdata;
    logic [31:0]         w_rd_mux;

    assign w_wr      = chipselect && !write_n;
    assign w_rd      = chipselect && !read_n;
    assign w_wdata   = writedata[WIDTH-1:0];
    assign w_restart = w_wr && (address == ADDR_PERIOD);

    nios_mtl_blink_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .period       (r_period),
        .restart      (w_restart),
        .period_reset (PERIOD_RESET),
        .phase        (w_phase)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= RESET_VALUE[WIDTH-1:0];
            r_blink_en <= '0;
            r_period   <= PERIOD_RESET;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:     r_data_out <= w_wdata;
                ADDR_BLINK_EN: r_blink_en <= w_wdata;
                ADDR_PERIOD:   r_period   <= writedata;
                ADDR_OUTSET:   r_data_out <= r_data_out | w_wdata;
                ADDR_OUTCLEAR: r_data_out <= r_data_out & ~w_wdata;
                default:       ;
            endcase
        end
    end

    // Mux sees pre-write register values, so a same-cycle write+read returns the old contents.
    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:     w_rd_mux[WIDTH-1:0] = r_data_out;
            ADDR_BLINK_EN: w_rd_mux[WIDTH-1:0] = r_blink_en;
            ADDR_PERIOD:   w_rd_mux            = r_period;
            ADDR_STATUS:   w_rd_mux[0]         = w_phase;
            default:       w_rd_mux            = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_data_out & ~(r_blink_en & {WIDTH{~w_phase}});

endmodule

// File: tb/tb_nios_mtl_led_pio.sv
// Directed bench for nios_mtl_led_pio: vector table for register access, hand sequences for blink timing.
module tb_nios_mtl_led_pio;

    localparam logic [31:0] PRST = 32'd12_499_999;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_vec  = 0;
    int n_fail = 0;

    nios_mtl_led_pio #(
        .WIDTH        (8),
        .RESET_VALUE  (32'h0000_00A5),
        .PERIOD_RESET (PRST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;
    endtask

    // One bus cycle; returns #1 after the capturing edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic rd(input logic [2:0] a);
        @(negedge clk);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = a;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    initial begin
        vecs[0]  = '{1'b0, 3'd0, 32'h0,         8'hA5, 32'h0000_00A5};
        vecs[1]  = '{1'b0, 3'd1, 32'h0,         8'hA5, 32'h0};
        vecs[2]  = '{1'b0, 3'd2, 32'h0,         8'hA5, PRST};
        vecs[3]  = '{1'b0, 3'd3, 32'h0,         8'hA5, 32'h1};
        vecs[4]  = '{1'b0, 3'd6, 32'h0,         8'hA5, 32'h0};
        vecs[5]  = '{1'b1, 3'd0, 32'hFFFF_FF0F, 8'h0F, 32'h0};
        vecs[6]  = '{1'b1, 3'd4, 32'hABCD_12C0, 8'hCF, 32'h0};
        vecs[7]  = '{1'b1, 3'd5, 32'hFFFF_0003, 8'hCC, 32'h0};
        vecs[8]  = '{1'b0, 3'd0, 32'h0,         8'hCC, 32'h0000_00CC};
        vecs[9]  = '{1'b0, 3'd4, 32'h0,         8'hCC, 32'h0};
        vecs[10] = '{1'b1, 3'd6, 32'h0000_00FF, 8'hCC, 32'h0};
        vecs[11] = '{1'b0, 3'd7, 32'h0,         8'hCC, 32'h0};
        vecs[12] = '{1'b0, 3'd5, 32'h0,         8'hCC, 32'h0};

        bus_idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_port", {24'd0, out_port}, 32'hA5);
        chk("reset_readdata", readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) begin
                wr(vecs[i].addr, vecs[i].wdata);
            end else begin
                rd(vecs[i].addr);
                chk($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
            end
            chk($sformatf("vec%0d_out_port", i), {24'd0, out_port}, {24'd0, vecs[i].exp_out});
        end

        // Blink: PERIOD=3 gives 4-cycle levels on bit 0.
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'h01);
        wr(3'd2, 32'd3);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = 3'd3;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("blink_out_k%0d", k), {24'd0, out_port},
                (((k / 4) % 2) == 0) ? 32'hFF : 32'hFE);
            if (k >= 1) begin
                chk($sformatf("blink_status_k%0d", k), readdata,
                    ((((k - 1) / 4) % 2) == 0) ? 32'h1 : 32'h0);
            end
            @(posedge clk);
            #1;
        end
        bus_idle();

        // PERIOD=0 parks phase high: fully-enabled blink still shows DATA.
        wr(3'd2, 32'd0);
        wr(3'd1, 32'hFF);
        wr(3'd0, 32'h5A);
        for (int k = 0; k < 100; k++) begin
            chk($sformatf("period0_out_k%0d", k), {24'd0, out_port}, 32'h5A);
            @(posedge clk);
            #1;
        end

        // PERIOD write on the wrap edge: restart wins, read returns old PERIOD.
        wr(3'd1, 32'h01);
        wr(3'd0, 32'hFF);
        wr(3'd2, 32'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        read_n     = 1'b0;
        address    = 3'd2;
        writedata  = 32'd5;
        @(posedge clk);
        #1;
        bus_idle();
        chk("wrap_restart_out", {24'd0, out_port}, 32'hFF);
        chk("wrap_old_period", readdata, 32'd3);
        for (int k = 1; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("wrap_out_k%0d", k), {24'd0, out_port}, (k < 6) ? 32'hFF : 32'hFE);
        end
        chk("readdata_hold", readdata, 32'd3);
        rd(3'd2);
        chk("period_new", readdata, 32'd5);

        // Reset while blinking with a DATA write pending.
        wr(3'd0, 32'h3C);
        @(negedge clk);
        reset      = 1'b1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 32'h00;
        @(posedge clk);
        #1;
        chk("rst_mid_out", {24'd0, out_port}, 32'hA5);
        chk("rst_mid_readdata", readdata, 32'h0);
        bus_idle();
        @(negedge clk);
        reset = 1'b0;
        rd(3'd0);
        chk("rst_data", readdata, 32'hA5);
        rd(3'd1);
        chk("rst_blink_en", readdata, 32'h0);
        rd(3'd2);
        chk("rst_period", readdata, PRST);
        rd(3'd3);
        chk("rst_status", readdata, 32'h1);
        chk("rst_out_final", {24'd0, out_port}, 32'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_mtl_led_pio.md
# nios_mtl_led_pio

Parametrised Avalon-MM output PIO for the board LEDs: the next generation of the fixed 8-bit LED port. It adds a configurable width, atomic bit set/clear, per-bit hardware blinking from a programmable prescaler, and registered read-back. It sits on the Nios II data master's Avalon interconnect; its `out_port` drives LED pins directly.

## Interface
- `WIDTH`, 8: output port width, legal 1..32.
- `RESET_VALUE`, 0: `data_out` value after reset (lower `WIDTH` bits used).
- `PERIOD_RESET`, 32'd12_499_999: prescaler compare value after reset.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  3  word address; see register map.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `read_n`  in  1  active-low read strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `out_port`  out  WIDTH  LED drive.

## Operation
- Register map (word address):
  - 0 DATA: rw, `data_out[WIDTH-1:0]`.
  - 1 BLINK_EN: rw, per-bit blink enable.
  - 2 PERIOD: rw, 32-bit prescaler compare.
  - 3 STATUS: ro, bit 0 = blink `phase`.
  - 4 OUTSET: wo, `data_out <= data_out | writedata[WIDTH-1:0]`.
  - 5 OUTCLEAR: wo, `data_out <= data_out & ~writedata[WIDTH-1:0]`.
  - 6, 7: reserved. Writes are ignored; reads return 0.
- Write: `chipselect && !write_n`, taken on the rising edge of `clk`. Bits of `writedata` above `WIDTH` are ignored.
- Blink timer: 32-bit `count`.
  - When `PERIOD != 0`: if `count == PERIOD`, then `count <= 0` and `phase <= ~phase`; otherwise `count` increments.
  - Half-period is therefore `PERIOD+1` cycles.
  - When `PERIOD == 0`: `count` is held at 0 and `phase` is held at 1, so there is no blinking.
- Writing PERIOD loads the new value, forces `count <= 0` and `phase <= 1`. This restart takes priority over the wrap in the same cycle.
- Output: `out_port = data_out & ~(blink_en & {WIDTH{~phase}})`. This is combinational from registers only, with no path from the bus inputs.
- A read returns OS/RO register contents zero-extended to 32 bits. OUTSET and OUTCLEAR read as 0.
- If a write and a read hit the same register in one cycle, the read returns the pre-write value.

## Timing
- Reset values:
  - `data_out = RESET_VALUE`, `blink_en = 0`, `PERIOD = PERIOD_RESET`.
  - `count = 0`, `phase = 1`, `readdata = 0`.
  - Therefore `out_port = RESET_VALUE[WIDTH-1:0]`.
- Write latency: a register written at edge N is reflected on `out_port` immediately after edge N.
- Read latency: exactly 1 cycle. `readdata` updates at the edge after `chipselect && !read_n` and holds until the next read. No waitrequest.
- Reset mid-blink: the synchronous reset overrides everything in that cycle, including a write and a wrap.
- Changing BLINK_EN does not disturb `count` or `phase`. A newly enabled bit follows the current `phase` immediately.

## Structure
- Package `nios_mtl_led_pio_pkg`:
  - address constants `ADDR_DATA`, `ADDR_BLINK_EN`, `ADDR_PERIOD`, `ADDR_STATUS`, `ADDR_OUTSET`, `ADDR_OUTCLEAR`;
  - `PERIOD_W = 32`.
- Sub-module `nios_mtl_blink_timer`:
  - inputs: `clk`, `reset`, `period`, `restart`, `period_reset`;
  - output: `phase`.
  - It owns `count` and `phase`.
- The top level holds the registers, write decode, read mux and output gating.

## Test plan
- Reset with `WIDTH=8`, `RESET_VALUE=8'hA5` -> `out_port=8'hA5`. Reads: DATA=`0xA5`, BLINK_EN=0, PERIOD=`PERIOD_RESET`, STATUS=1.
- Write DATA `0x0F`, then OUTSET `0xC0`, then OUTCLEAR `0x03` -> `out_port` is `0x0F`, `0xCF`, `0xCC` on successive cycles. DATA reads `0xCC`. Bits 31:8 are ignored.
- PERIOD=3, BLINK_EN=`0x01`, DATA=`0xFF` -> `out_port` alternates `0xFF` / `0xFE`. Each level lasts exactly 4 cycles. STATUS bit 0 tracks the toggling.
- PERIOD=0 with BLINK_EN=`0xFF` -> `out_port` stays equal to DATA for 100 cycles.
- Write PERIOD in the same cycle as a scheduled wrap -> `phase=1` and `count=0` the next cycle, with no toggle. A read issued in the write cycle returns the old PERIOD. Readdata is valid exactly 1 cycle later.
- Assert `reset` while blinking with a write pending -> all registers return to reset values, `out_port=RESET_VALUE`, and the write is discarded.
